// File: rtl/hpdmc_initseq_pkg.sv
// ============================================================================
// hpdmc_initseq_pkg: shared states, SDRAM command words and CSR register
// indices for the SDRAM power-up sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hpdmc_initseq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_CKE  = 4'd1,
    ST_PRE1 = 4'd2,
    ST_EMRS = 4'd3,
    ST_MRSD = 4'd4,
    ST_PRE2 = 4'd5,
    ST_REF1 = 4'd6,
    ST_REF2 = 4'd7,
    ST_MRS  = 4'd8,
    ST_TIMW = 4'd9,
    ST_RUN  = 4'd10
  } state_t;

  localparam logic [31:0] CMD_PRE    = 32'h0000_400B;
  localparam logic [31:0] CMD_REF    = 32'h0000_000D;
  localparam logic [31:0] CMD_LMR    = 32'h0000_000F;
  localparam logic [31:0] CMD_CKE_ON = 32'h0000_0007;
  localparam logic [31:0] CMD_RUN_ON = 32'h0000_0004;
  // Bank-address bit that steers a load-mode command to the extended register
  localparam logic [31:0] BA_EMR     = 32'h0002_0000;

  localparam logic [1:0] REG_SYS = 2'd0;
  localparam logic [1:0] REG_CMD = 2'd1;
  localparam logic [1:0] REG_TIM = 2'd2;

  function automatic logic [31:0] lmr_word(input logic [12:0] mode);
    return CMD_LMR | {15'd0, mode, 4'd0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/hpdmc_initseq_if.sv
// ============================================================================
// hpdmc_initseq_if: CSR bus (address, write strobe, write data, read data).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hpdmc_initseq_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (output csr_a, output csr_we, output csr_di, input csr_do);
  modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

`default_nettype wire

// File: rtl/hpdmc_initseq_timer.sv
// ============================================================================
// hpdmc_initseq_timer: 16-bit loadable down-counter that stops at zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hpdmc_initseq_timer (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_load,
  input  wire logic [15:0] i_value,
  output logic      [15:0] o_value,
  output logic             o_zero
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                r_cnt <= 16'd0;
    else if (i_load)        r_cnt <= i_value;
    else if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
  end

  assign o_value = r_cnt;
  assign o_zero  = (r_cnt == 16'd0);

endmodule

`default_nettype wire

// File: rtl/hpdmc_initseq.sv
// ============================================================================
// hpdmc_initseq: issues the SDRAM power-up command sequence through the
// controller CSR port and passes host CSR traffic through while idle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hpdmc_initseq
  import hpdmc_initseq_pkg::*;
#(
  parameter logic [3:0]  csr_addr = 4'h0,
  parameter int          T_INIT   = 20000,
  parameter int          T_RP     = 4,
  parameter int          T_RFC    = 12,
  parameter int          T_DLL    = 200,
  parameter logic [12:0] MR       = 13'h033,
  parameter logic [12:0] EMR      = 13'h000,
  parameter logic [31:0] TIM      = 32'h0000_1F09
) (
  input  wire logic         sys_clk,
  input  wire logic         sys_rst,
  input  wire logic         start,
  output logic              busy,
  output logic              done,
  hpdmc_initseq_if.slave    h_csr,
  hpdmc_initseq_if.master   m_csr
);

  state_t      r_state;
  state_t      w_next;
  state_t      w_succ;
  logic        r_first;
  logic        r_done;
  logic [13:0] r_last_a;
  logic [1:0]  w_reg;
  logic [31:0] w_data;
  logic [15:0] w_delay;
  logic [13:0] w_addr;
  logic        w_idle;
  logic        w_load;
  logic [15:0] w_tmr_val;
  logic        w_tmr_zero;

  assign w_idle = (r_state == ST_IDLE);
  assign w_load = !w_idle && r_first;
  assign w_addr = {csr_addr, 8'd0, w_reg};

  // Per-state write target, payload, wait and successor
  always_comb begin
    w_succ  = ST_IDLE;
    w_reg   = REG_SYS;
    w_data  = 32'd0;
    w_delay = 16'd0;
    case (r_state)
      ST_CKE:  begin w_succ = ST_PRE1; w_reg = REG_SYS; w_data = CMD_CKE_ON;               w_delay = 16'(T_INIT); end
      ST_PRE1: begin w_succ = ST_EMRS; w_reg = REG_CMD; w_data = CMD_PRE;                  w_delay = 16'(T_RP);   end
      ST_EMRS: begin w_succ = ST_MRSD; w_reg = REG_CMD; w_data = BA_EMR | lmr_word(EMR);   w_delay = 16'd2;       end
      ST_MRSD: begin w_succ = ST_PRE2; w_reg = REG_CMD; w_data = lmr_word(MR | 13'h100);   w_delay = 16'(T_DLL);  end
      ST_PRE2: begin w_succ = ST_REF1; w_reg = REG_CMD; w_data = CMD_PRE;                  w_delay = 16'(T_RP);   end
      ST_REF1: begin w_succ = ST_REF2; w_reg = REG_CMD; w_data = CMD_REF;                  w_delay = 16'(T_RFC);  end
      ST_REF2: begin w_succ = ST_MRS;  w_reg = REG_CMD; w_data = CMD_REF;                  w_delay = 16'(T_RFC);  end
      ST_MRS:  begin w_succ = ST_TIMW; w_reg = REG_CMD; w_data = lmr_word(MR);             w_delay = 16'(T_DLL);  end
      ST_TIMW: begin w_succ = ST_RUN;  w_reg = REG_TIM; w_data = TIM;                      w_delay = 16'd0;       end
      ST_RUN:  begin w_succ = ST_IDLE; w_reg = REG_SYS; w_data = CMD_RUN_ON;               w_delay = 16'd0;       end
      default: begin w_succ = ST_IDLE; end
    endcase
  end

  // Leave a state when the counter is about to reach zero so the next write
  // lands exactly delay+1 cycles after this one.
  always_comb begin
    w_next = r_state;
    if (w_idle) begin
      if (start) w_next = ST_CKE;
    end else if (r_first) begin
      if (w_delay == 16'd0) w_next = w_succ;
    end else if (w_tmr_zero || (w_tmr_val == 16'd1)) begin
      w_next = w_succ;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= ST_IDLE;
      r_first  <= 1'b0;
      r_done   <= 1'b0;
      r_last_a <= 14'd0;
    end else begin
      r_state <= w_next;
      r_first <= (w_next != r_state) && (w_next != ST_IDLE);
      if (w_idle && start)                         r_done <= 1'b0;
      else if (r_state == ST_RUN && w_next == ST_IDLE) r_done <= 1'b1;
      if (w_load) r_last_a <= w_addr;
    end
  end

  hpdmc_initseq_timer u_timer (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .i_load  (w_load),
    .i_value (w_delay),
    .o_value (w_tmr_val),
    .o_zero  (w_tmr_zero)
  );

  // Host owns the controller port only while idle and not starting
  always_comb begin
    m_csr.csr_a  = r_last_a;
    m_csr.csr_we = 1'b0;
    m_csr.csr_di = 32'd0;
    h_csr.csr_do = 32'd0;
    if (w_idle) begin
      m_csr.csr_a  = h_csr.csr_a;
      m_csr.csr_we = h_csr.csr_we & ~start;
      m_csr.csr_di = h_csr.csr_di;
      h_csr.csr_do = m_csr.csr_do;
    end else if (r_first) begin
      m_csr.csr_a  = w_addr;
      m_csr.csr_we = 1'b1;
      m_csr.csr_di = w_data;
    end
  end

  assign busy = !w_idle;
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_hpdmc_initseq.sv
// ============================================================================
// tb_hpdmc_initseq: directed bench for the SDRAM power-up sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hpdmc_initseq;

  localparam logic [3:0] ADDR_PG = 4'h5;
  localparam int         TI = 10;
  localparam int         TRP = 4;
  localparam int         TRFC = 12;
  localparam int         TDLL = 200;

  typedef struct { int cyc; logic [13:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [13:0] a; logic [31:0] d; int gap; } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  wr_t  obs_q[$];
  exp_t exp_q[$];

  hpdmc_initseq_if h_bus ();
  hpdmc_initseq_if m_bus ();

  hpdmc_initseq #(
    .csr_addr (ADDR_PG),
    .T_INIT   (TI),
    .T_RP     (TRP),
    .T_RFC    (TRFC),
    .T_DLL    (TDLL),
    .MR       (13'h033),
    .EMR      (13'h002),
    .TIM      (32'h0000_1F09)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .h_csr   (h_bus.slave),
    .m_csr   (m_bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy && m_bus.csr_we) obs_q.push_back('{cyc, m_bus.csr_a, m_bus.csr_di});
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [13:0] adr(input logic [1:0] r);
    return {ADDR_PG, 8'd0, r};
  endfunction

  task automatic push_expected();
    exp_q.delete();
    exp_q.push_back('{adr(2'd0), 32'h0000_0007, 1});
    exp_q.push_back('{adr(2'd1), 32'h0000_400B, TI + 1});
    exp_q.push_back('{adr(2'd1), 32'h0002_002F, TRP + 1});
    exp_q.push_back('{adr(2'd1), 32'h0000_133F, 3});
    exp_q.push_back('{adr(2'd1), 32'h0000_400B, TDLL + 1});
    exp_q.push_back('{adr(2'd1), 32'h0000_000D, TRP + 1});
    exp_q.push_back('{adr(2'd1), 32'h0000_000D, TRFC + 1});
    exp_q.push_back('{adr(2'd1), 32'h0000_033F, TRFC + 1});
    exp_q.push_back('{adr(2'd2), 32'h0000_1F09, TDLL + 1});
    exp_q.push_back('{adr(2'd0), 32'h0000_0004, 1});
  endtask

  task automatic wait_obs(input int n);
    int k = 0;
    while (obs_q.size() < n && k < 2000) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("wait_writes", (obs_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_done(output int dc);
    int k = 0;
    dc = 0;
    while (k < 3000) begin
      @(negedge clk);
      #1;
      k++;
      if (done) break;
    end
    dc = cyc;
    check("done_set", {31'd0, done}, 32'd1);
  endtask

  // Pops expected against observed writes: address, data and spacing
  task automatic check_seq(input string tag, input int sc, input int dc);
    int prev;
    exp_t e;
    wr_t  o;
    prev = sc;
    check({tag, "_count"}, obs_q.size(), 32'd10);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_addr"}, {18'd0, o.a}, {18'd0, e.a});
      check({tag, "_data"}, o.d, e.d);
      check({tag, "_gap"}, o.cyc - prev, e.gap);
      prev = o.cyc;
    end
    check({tag, "_done_lat"}, dc - prev, 32'd1);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int sc;
    int dc;
    rst = 1'b1;
    start = 1'b0;
    h_bus.csr_a = 14'd0;
    h_bus.csr_we = 1'b0;
    h_bus.csr_di = 32'd0;
    m_bus.csr_do = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we", {31'd0, m_bus.csr_we}, 32'd0);
    rst = 1'b0;

    // Idle pass-through
    @(negedge clk);
    h_bus.csr_a = adr(2'd2);
    h_bus.csr_we = 1'b1;
    h_bus.csr_di = 32'hCAFE_0001;
    m_bus.csr_do = 32'h1234_5678;
    #1;
    check("idle_a", {18'd0, m_bus.csr_a}, {18'd0, adr(2'd2)});
    check("idle_we", {31'd0, m_bus.csr_we}, 32'd1);
    check("idle_di", m_bus.csr_di, 32'hCAFE_0001);
    check("idle_do", h_bus.csr_do, 32'h1234_5678);

    // Run 1: start accepted alongside a host write, host write during REF1
    @(negedge clk);
    start = 1'b1;
    sc = cyc;
    push_expected();
    #1;
    check("start_blocks_we", {31'd0, m_bus.csr_we}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    h_bus.csr_we = 1'b0;
    #1;
    check("run1_busy", {31'd0, busy}, 32'd1);
    check("run1_done_clr", {31'd0, done}, 32'd0);
    check("busy_do_zero", h_bus.csr_do, 32'd0);
    wait_obs(6);
    @(negedge clk);
    h_bus.csr_we = 1'b1;
    h_bus.csr_a = adr(2'd2);
    h_bus.csr_di = 32'hDEAD_BEEF;
    #1;
    check("ref1_we", {31'd0, m_bus.csr_we}, 32'd0);
    check("ref1_do", h_bus.csr_do, 32'd0);
    check("ref1_di", m_bus.csr_di, 32'd0);
    check("ref1_hold_a", {18'd0, m_bus.csr_a}, {18'd0, adr(2'd1)});
    @(negedge clk);
    h_bus.csr_we = 1'b0;
    wait_done(dc);
    check_seq("run1", sc, dc);

    // Run 2: start re-pulsed while busy
    @(negedge clk);
    start = 1'b1;
    sc = cyc;
    push_expected();
    @(negedge clk);
    start = 1'b0;
    #1;
    check("run2_done_clr", {31'd0, done}, 32'd0);
    wait_obs(3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(dc);
    check_seq("run2", sc, dc);

    // Run 3: reset in the MRSD wait, then a clean replay
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_obs(4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    obs_q.delete();
    repeat (5) @(negedge clk);
    #1;
    check("no_resume", obs_q.size(), 32'd0);
    @(negedge clk);
    start = 1'b1;
    sc = cyc;
    push_expected();
    @(negedge clk);
    start = 1'b0;
    wait_done(dc);
    check_seq("run3", sc, dc);

    // Run 4: start held for three cycles
    @(negedge clk);
    start = 1'b1;
    sc = cyc;
    push_expected();
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(dc);
    check_seq("run4", sc, dc);
    repeat (20) @(negedge clk);
    #1;
    check("held_single", obs_q.size(), 32'd0);
    check("held_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
